// File: rtl/tcb_axis_img_packer.sv
// AXI-Stream front end for the TCB classifier: packs 32-bit beats into an 11x11x8 image
// and returns each 8-bit class result to the DMA as a single-beat packet.
module tcb_axis_img_packer #(
    parameter int PIX_W  = 8,
    parameter int N_PIX  = 121,
    parameter int AXIS_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXIS_W-1:0]         s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [PIX_W*N_PIX-1:0]    img_source,
    output logic                      valid_top,
    input  logic                      ready_top,
    input  logic                      res_valid,
    input  logic [7:0]                res_number,
    output logic [AXIS_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      frame_err,
    output logic                      res_ovf,
    output logic [15:0]               frame_cnt
);

    localparam int IMG_W     = PIX_W * N_PIX;
    localparam int BEATS     = (IMG_W + AXIS_W - 1) / AXIS_W;
    localparam int LANES     = AXIS_W / PIX_W;
    localparam int BEAT_CW   = $clog2(BEATS);
    localparam int LAST_BEAT = BEATS - 1;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        DRAIN   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [BEAT_CW-1:0]   beat_reg, beat_next;
    logic                 tready_reg;
    logic                 valid_reg;
    logic                 frame_err_reg;
    logic                 err_set;
    logic                 frame_done;
    logic [15:0]          frame_cnt_reg;
    logic                 xfer;
    logic                 fill_xfer;
    logic                 last_beat;

    logic [PIX_W-1:0]     pix_reg [N_PIX];

    logic                 res_valid_reg;
    logic [7:0]           res_reg;
    logic                 res_ovf_reg;
    logic                 m_accept;

    assign xfer      = s_axis_tvalid & tready_reg;
    assign fill_xfer = xfer & (state_reg == FILL);
    assign last_beat = (beat_reg == BEAT_CW'(LAST_BEAT));

    // ---------------- image FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        err_set    = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            FILL: begin
                if (xfer) begin
                    if (last_beat) begin
                        beat_next = '0;
                        if (s_axis_tlast) begin
                            state_next = PRESENT;
                        end else begin
                            err_set    = 1'b1;
                            state_next = DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        // short frame: restart packing from beat 0
                        err_set   = 1'b1;
                        beat_next = '0;
                    end else begin
                        beat_next = beat_reg + BEAT_CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (xfer && s_axis_tlast) begin
                    state_next = FILL;
                    beat_next  = '0;
                end
            end
            PRESENT: begin
                if (ready_top) begin
                    state_next = FILL;
                    beat_next  = '0;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_next = FILL;
                beat_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_reg      <= '0;
            tready_reg    <= 1'b0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            beat_reg   <= beat_next;
            tready_reg <= (state_next != PRESENT);
            valid_reg  <= (state_next == PRESENT);
            if (err_set) begin
                frame_err_reg <= 1'b1;
            end
            if (frame_done) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    // Each pixel owns a register written from its fixed beat/lane; pixel 0 lands at the MSB.
    generate
        for (genvar gi = 0; gi < N_PIX; gi++) begin : g_pix
            localparam int PIX_BEAT = gi / LANES;
            localparam int PIX_LANE = gi % LANES;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pix_reg[gi] <= '0;
                end else if (fill_xfer && (beat_reg == BEAT_CW'(PIX_BEAT))) begin
                    pix_reg[gi] <= s_axis_tdata[PIX_LANE*PIX_W +: PIX_W];
                end
            end

            assign img_source[IMG_W-1-PIX_W*gi -: PIX_W] = pix_reg[gi];
        end
    endgenerate

    // ---------------- result path ----------------
    assign m_accept = res_valid_reg & m_axis_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_reg <= 1'b0;
            res_reg       <= '0;
            res_ovf_reg   <= 1'b0;
        end else begin
            if (res_valid && (!res_valid_reg || m_accept)) begin
                res_valid_reg <= 1'b1;
                res_reg       <= res_number;
            end else if (m_accept) begin
                res_valid_reg <= 1'b0;
            end else if (res_valid) begin
                // buffer full and not draining: keep the old result
                res_ovf_reg <= 1'b1;
            end
        end
    end

    assign s_axis_tready = tready_reg;
    assign valid_top     = valid_reg;
    assign frame_err     = frame_err_reg;
    assign frame_cnt     = frame_cnt_reg;
    assign m_axis_tdata  = {{(AXIS_W-8){1'b0}}, res_reg};
    assign m_axis_tvalid = res_valid_reg;
    assign m_axis_tlast  = res_valid_reg;
    assign res_ovf       = res_ovf_reg;

endmodule

// File: doc/tcb_axis_img_packer.md
Name: tcb_axis_img_packer

Overview:
- Host-side front end for the TCB classifier on the ZCU104 AXI-stream path.
- Receives 32-bit AXI-Stream beats from the DMA and packs them into one 968-bit image (121 pixels × 8 bits, 11×11).
- Presents the image to the classifier with a valid/ready handshake.
- Returns each 8-bit class result to the DMA as a single-beat AXI-Stream packet.

Parameters:
- PIX_W, 8, bits per pixel.
- N_PIX, 121, pixels per image.
- AXIS_W, 32, s_axis/m_axis data width.
- Derived (localparam, not overridable):
  - IMG_W = PIX_W*N_PIX = 968.
  - BEATS = ceil(IMG_W/AXIS_W) = 31.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  AXIS_W  image beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accept.
- s_axis_tlast  in  1  last beat of image.
- img_source  out  IMG_W  packed image to classifier.
- valid_top  out  1  image valid.
- ready_top  in  1  classifier accepts image.
- res_valid  in  1  classifier result strobe (1-cycle pulse).
- res_number  in  8  classifier result.
- m_axis_tdata  out  AXIS_W  result beat, {24'b0, number}.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  DMA accepts result.
- m_axis_tlast  out  1  always 1 while m_axis_tvalid is high.
- frame_err  out  1  sticky: tlast at a wrong beat.
- res_ovf  out  1  sticky: result dropped.
- frame_cnt  out  16  images handed to classifier, wraps at 0xFFFF→0.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=FILL, beat counter=0.
  - img_source=0, valid_top=0, s_axis_tready=0 on the reset cycle, then 1 in FILL.
  - m_axis_tvalid=0, m_axis_tdata=0.
  - frame_err=0, res_ovf=0, frame_cnt=0.
- Reset mid-frame discards the partial image and any pending result.
- Packing order:
  - Pixel 0 is the first byte received, s_axis_tdata[7:0] of beat 0.
  - Pixel k occupies img_source[IMG_W-1-8k -: 8], so pixel 0 sits at the MSB, row-major.
  - Beat b carries pixels 4b..4b+3 in tdata byte lanes 0..3.
  - Beat 30 carries only pixel 120, in lane 0; lanes 1..3 are ignored.
- A transfer occurs when tvalid & tready are both high on a rising edge.
- FSM:
  - FILL
    - s_axis_tready=1.
    - Each transfer writes the bytes for the current beat and increments the beat counter.
    - Transfer with beat=30 and tlast=1 → PRESENT.
    - Transfer with beat=30 and tlast=0 → set frame_err, go to DRAIN, image discarded.
    - Transfer with tlast=1 and beat<30 → set frame_err, reset beat counter to 0, stay in FILL, image discarded.
  - DRAIN
    - s_axis_tready=1, beats discarded.
    - Transfer with tlast=1 → FILL, beat counter=0.
  - PRESENT
    - s_axis_tready=0, valid_top=1.
    - img_source is stable for the whole state.
    - When ready_top=1 on an edge: valid_top drops next cycle, frame_cnt increments, beat counter=0, → FILL.
- valid_top is registered.
- Minimum latency: valid_top rises the cycle after the tlast transfer.
- Back-to-back throughput: 31 beats + 1 handshake cycle per image.
- img_source keeps its last value outside PRESENT; bytes are overwritten in place during FILL.
- Result path (1-entry buffer, independent of the image FSM):
  - res_valid with the buffer empty: load res_number; m_axis_tvalid=1 next cycle.
  - Accept (m_axis_tvalid & m_axis_tready): buffer empties.
  - res_valid in the same cycle as an accept: load the new value; tvalid stays 1.
  - res_valid with the buffer full and no accept: new value dropped, res_ovf set, old value retained.
  - m_axis_tdata is stable while tvalid=1 and not accepted.
- frame_err and res_ovf clear only on reset.

Test Plan:
- Send 31 beats with increasing bytes 0x00..0x78 (lane-packed), tlast on beat 30 → valid_top=1 the next cycle, img_source[967:960]=0x00, img_source[7:0]=0x78, s_axis_tready=0.
- Hold ready_top=0 for 5 cycles, then pulse it for 1 cycle → img_source stable throughout, valid_top=0 the following cycle, frame_cnt=1, s_axis_tready=1.
- Send tlast on beat 10 → frame_err=1, no valid_top. Then send a clean 31-beat frame → valid_top=1 with the new data only.
- Send 33 beats with tlast on beat 32 → frame_err=1, FSM in DRAIN after beat 30, returns to FILL after beat 32, no valid_top.
- res_valid with res_number=0x07 and m_axis_tready=0 → m_axis_tdata=0x00000007, tlast=1. A second res_valid with 0x03 → res_ovf=1, data stays 0x07. Then raise m_axis_tready → single beat 0x07 transfers, tvalid=0.
- Assert rst=0 asynchronously mid-FILL (beat 15) and while a result is pending → all outputs at reset values immediately. After release, a full frame packs correctly from beat 0.
